// File: rtl/niosmp_chtx.sv
// Avalon-MM character transmitter: one 8N1 serial frame per TXDATA write, with busy/overrun status.
// Define NIOSMP_CHTX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module niosmp_chtx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_port
);

`ifdef NIOSMP_CHTX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [2:0]  bit_idx, idx_nx;
    logic [7:0]  txdata, txdata_nx;
    logic        out_nx;
    logic        overrun, ovr_nx;
    logic        busy;
    logic        wr_tx, wr_st;
    logic [31:0] rd_mux;

    logic unused_wdata;
    assign unused_wdata = ^writedata[31:8];

    assign busy  = (state != IDLE);
    assign wr_tx = chipselect && !write_n && (address == 2'd0);
    assign wr_st = chipselect && !write_n && (address == 2'd1);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        idx_nx    = bit_idx;
        out_nx    = out_port;
        txdata_nx = txdata;
        ovr_nx    = overrun;

        // Clear first so a same-cycle set takes priority.
        if (wr_st && writedata[1]) ovr_nx = 1'b0;
        if (wr_tx && busy)         ovr_nx = 1'b1;

        case (state)
            IDLE: begin
                out_nx = 1'b1;
                if (wr_tx) begin
                    txdata_nx = writedata[7:0];
                    state_nx  = START;
                    cnt_nx    = RELOAD;
                    idx_nx    = 3'd0;
                    out_nx    = 1'b0;
                end
            end
            START: begin
                if (cnt == 16'd0) begin
                    state_nx = DATA;
                    cnt_nx   = RELOAD;
                    idx_nx   = 3'd0;
                    out_nx   = txdata[0];
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == 16'd0) begin
                    cnt_nx = RELOAD;
                    if (bit_idx == 3'd7) begin
`ifdef NIOSMP_CHTX_PARITY_EN
                        state_nx = PARITY;
                        out_nx   = ^txdata;
`else
                        state_nx = STOP;
                        out_nx   = 1'b1;
`endif
                    end else begin
                        idx_nx = bit_idx + 3'd1;
                        out_nx = txdata[idx_nx];
                    end
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
`ifdef NIOSMP_CHTX_PARITY_EN
            PARITY: begin
                if (cnt == 16'd0) begin
                    state_nx = STOP;
                    cnt_nx   = RELOAD;
                    out_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt == 16'd0) begin
                    state_nx = IDLE;
                    cnt_nx   = 16'd0;
                    out_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 16'd0;
                out_nx   = 1'b1;
            end
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        case (address)
            2'd0:    rd_mux = {24'd0, txdata};
            2'd1:    rd_mux = {30'd0, overrun, busy};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            bit_idx  <= 3'd0;
            txdata   <= 8'd0;
            out_port <= 1'b1;
            overrun  <= 1'b0;
            readdata <= 32'd0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            bit_idx  <= idx_nx;
            txdata   <= txdata_nx;
            out_port <= out_nx;
            overrun  <= ovr_nx;
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_niosmp_chtx.sv
// Bench for niosmp_chtx: time-based frame model checked every cycle, plus directed literal checks.
module tb_niosmp_chtx;
    localparam int CPB = 4;
`ifdef NIOSMP_CHTX_PARITY_EN
    localparam int NB  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 10;
    localparam bit PAR = 1'b0;
`endif
    localparam int FLEN = NB * CPB;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        out_port;

    niosmp_chtx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is just a start edge number plus a character; line level is arithmetic on elapsed cycles.
    int         cyc = 0;
    int         f_start = -100000;
    logic [7:0] f_char = 8'd0;
    logic [7:0] last = 8'd0;
    logic       ovr = 1'b0;
    logic [31:0] exp_rd = 32'd0;

    function automatic bit m_busy(input int c);
        int idx;
        idx = c - f_start;
        return (idx >= 0) && (idx < FLEN);
    endfunction

    function automatic logic m_line(input int c);
        int idx, k;
        idx = c - f_start;
        if (idx < 0 || idx >= FLEN) return 1'b1;
        k = idx / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return f_char[k-1];
        if (k == 9 && PAR) return ^f_char;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit bp;
        cyc++;
        bp = m_busy(cyc - 1);
        if (!reset_n) begin
            f_start = -100000;
            ovr     = 1'b0;
            last    = 8'd0;
            exp_rd  = 32'd0;
        end else begin
            exp_rd = (address == 2'd0) ? {24'd0, last} :
                     (address == 2'd1) ? {30'd0, ovr, bp} : 32'd0;
            if (chipselect && !write_n) begin
                if (address == 2'd1 && writedata[1]) ovr = 1'b0;
                if (address == 2'd0) begin
                    if (bp) ovr = 1'b1;
                    else begin
                        last    = writedata[7:0];
                        f_char  = writedata[7:0];
                        f_start = cyc;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("model_line", {31'd0, out_port}, {31'd0, m_line(cyc)});
            chk("model_rd", readdata, exp_rd);
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        @(negedge clk);
        address = a;
        @(negedge clk);
        v = readdata;
        address = 2'd0;
    endtask

    logic [31:0] v;
    logic [10:0] lit55;

    initial begin
`ifdef NIOSMP_CHTX_PARITY_EN
        lit55 = 11'b1_0_01010101_0;
`else
        lit55 = 11'b1_1_01010101_0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_line", {31'd0, out_port}, 32'd1);
        chk("reset_rd", readdata, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0x55 frame, first cycle of each bit against literal pattern
        wr(2'd0, 32'h55);
        for (int i = 0; i < FLEN; i++) begin
            if (i % CPB == 0) chk("bit55", {31'd0, out_port}, {31'd0, lit55[i/CPB]});
            @(negedge clk);
        end
        chk("idle_after55", {31'd0, out_port}, 32'd1);
        rd(2'd1, v);
        chk("status_idle", v, 32'h0);

        // overrun during frame
        wr(2'd0, 32'h55);
        repeat (5) @(negedge clk);
        wr(2'd0, 32'h12);
        rd(2'd1, v);
        chk("status_ovr_busy", v, 32'h3);
        repeat (FLEN) @(negedge clk);
        rd(2'd1, v);
        chk("status_ovr_idle", v, 32'h2);
        rd(2'd0, v);
        chk("txdata_kept", v, 32'h55);
        wr(2'd1, 32'h2);
        rd(2'd1, v);
        chk("status_cleared", v, 32'h0);

        // reset in data bit 3
        wr(2'd0, 32'h33);
        repeat (17) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort_line", {31'd0, out_port}, 32'd1);
        rd(2'd1, v);
        chk("abort_status", v, 32'h0);
        wr(2'd0, 32'hA0);
        repeat (FLEN + 2) @(negedge clk);

        // back-to-back frames
        wr(2'd0, 32'h01);
        repeat (FLEN - 1) @(negedge clk);
        chk("b2b_gap_high", {31'd0, out_port}, 32'd1);
        wr(2'd0, 32'h80);
        chk("b2b_start", {31'd0, out_port}, 32'd0);
        rd(2'd1, v);
        chk("b2b_no_ovr", v, 32'h1);
        repeat (FLEN) @(negedge clk);

        // bit after data: parity or stop
        wr(2'd0, 32'h07);
        repeat (36) @(negedge clk);
        chk("after_data_07", {31'd0, out_port}, 32'd1);
        repeat (FLEN) @(negedge clk);
        wr(2'd0, 32'h03);
        repeat (36) @(negedge clk);
        chk("after_data_03", {31'd0, out_port}, PAR ? 32'd0 : 32'd1);
        repeat (FLEN) @(negedge clk);

        // readback
        wr(2'd0, 32'hC3);
        rd(2'd0, v);
        chk("rd_txdata", v, 32'hC3);
        rd(2'd2, v);
        chk("rd_addr2", v, 32'h0);
        wr(2'd2, 32'hFF);
        rd(2'd0, v);
        chk("addr2_ignored", v, 32'hC3);
        repeat (FLEN + 2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/niosmp_chtx.md
NIOSMP_CHTX -- requirements
Module: niosmp_chtx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 address  input  2  Avalon-MM slave word address.
REQ-005 chipselect  input  1  slave select; qualifies reads and writes.
REQ-006 write_n  input  1  active-low write strobe.
REQ-007 writedata  input  32  write data; only bits [7:0] used.
REQ-008 readdata  output  32  registered read data, zero-extended.
REQ-009 out_port  output  1  serial character line, idle high.

Function
REQ-010 Register map SHALL be: addr 0 TXDATA (W: char [7:0]; R: last accepted char); addr 1 STATUS (R: bit0 busy, bit1 overrun; W: bit1=1 clears overrun); addr 2/3 read 0, writes ignored.
REQ-011 A write is chipselect=1 and write_n=0 in a cycle; no wait states, accepted or discarded in that cycle.
REQ-012 readdata SHALL update every cycle with the mux value for the current address (chipselect ignored on read), one-cycle latency, upper bits zero.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-014 TXDATA write in IDLE at edge N: char latched, busy=1 and out_port=0 (START) from edge N+1.
REQ-015 Each state SHALL hold out_port for exactly CLKS_PER_BIT cycles via a down-counter reloaded on each bit boundary.
REQ-016 DATA SHALL send 8 bits LSB first, 3-bit index 0..7; after bit 7 go to PARITY (if enabled) else STOP.
REQ-017 STOP SHALL drive out_port=1 for CLKS_PER_BIT cycles, then go IDLE and clear busy on the same edge.
REQ-018 Frame = 10 bit-times (11 with parity); busy high exactly that many x CLKS_PER_BIT cycles.
REQ-019 TXDATA write while busy=1 SHALL be discarded, set overrun, and not disturb the frame in flight.
REQ-020 Write in the first cycle busy reads 0 SHALL be accepted; back-to-back frames need no extra idle bit-times.
REQ-021 Simultaneous overrun set and clear in the same cycle: set wins.
REQ-022 out_port SHALL come directly from a flop (glitch-free).

Reset
REQ-023 reset_n=0 at an edge SHALL force state IDLE, out_port=1, busy=0, overrun=0, TXDATA=0, counters=0, readdata=0, regardless of frame in progress.
REQ-024 Writes with reset_n=0 SHALL be ignored.

Configuration
REQ-025 Macro NIOSMP_CHTX_PARITY_EN defined: PARITY state sends even parity (XOR of the 8 data bits) between data bit 7 and STOP.
REQ-026 Macro undefined: PARITY state and its logic absent; frame is 10 bit-times.

Verification (bench CLKS_PER_BIT=4)
REQ-027 Write 0x55 to addr 0 in IDLE -> from next edge out_port 0,1,0,1,0,1,0,1,0,1, each 4 cycles; busy=1 for 40 cycles, then 0.
REQ-028 Write 0x12 during 0x55 frame -> frame unchanged, STATUS reads 0x3 while busy, then 0x2; write 0x2 to addr 1 -> STATUS reads 0x0.
REQ-029 reset_n low for 1 cycle in DATA bit 3 -> out_port=1, busy=0 next edge; subsequent write 0xA0 sends correct full frame.
REQ-030 Write 0x01, then 0x80 in first cycle busy=0 -> two contiguous 40-cycle frames, no extra idle high between them.
REQ-031 With NIOSMP_CHTX_PARITY_EN, write 0x07 -> parity bit 1 after data, busy=1 for 44 cycles; write 0x03 -> parity bit 0.
REQ-032 Read addr 0 after 0xC3 accepted -> readdata=0x000000C3 one cycle after address presented; addr 2 reads 0.
